// File: rtl/reg_group_ctrl_pkg.sv
// Shared opcode, register-code and state definitions for the register-group sequencer.
package reg_group_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDI = 4'd1,
    OP_MOV = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_NOT = 4'd8,
    OP_INC = 4'd9
  } op_e;

  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_C   = 2'b10;
  localparam logic [1:0] REG_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IMM   = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // The src field is only checked for ops that actually read it; NOP checks nothing.
  function automatic logic instr_legal(input logic [7:0] instr);
    logic [3:0] op;
    logic       src_used;
    op       = instr[7:4];
    src_used = (op >= 4'd2) && (op <= 4'd8);
    if (op > 4'd9) return 1'b0;
    if (op == 4'd0) return 1'b1;
    if (instr[1:0] == REG_BAD) return 1'b0;
    if (src_used && (instr[3:2] == REG_BAD)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/reg_group_ctrl_if.sv
// Instruction/immediate byte stream into the sequencer (valid/ready).
interface reg_group_ctrl_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/reg_group_ctrl_alu.sv
// Combinational ALU: a is the destination register (d port), b the source (s port).
module reg_group_ctrl_alu
  import reg_group_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] ext;

  // Bit DW carries the carry-out for ADD/INC and the borrow for SUB; zero elsewhere.
  always_comb begin
    ext = '0;
    case (op)
      OP_MOV:  ext = {1'b0, b};
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      OP_NOT:  ext = {1'b0, ~b};
      OP_INC:  ext = {1'b0, a} + (DW+1)'(1);
      default: ext = '0;
    endcase
  end

  assign result = ext[DW-1:0];
  assign carry  = ext[DW];
  assign zero   = ~|ext[DW-1:0];

endmodule

// File: rtl/reg_group_ctrl.sv
// Instruction sequencer for the 3-entry register group: decode, read s/d, ALU, write back.
// All outputs are registered so we_n can only fall for exactly the WRITE cycle.
module reg_group_ctrl
  import reg_group_ctrl_pkg::*;
#(
  parameter int DW          = 8,
  parameter int IMM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  reg_group_ctrl_if.slave host,
  output logic [1:0]    raa,
  output logic [1:0]    rwba,
  output logic          we_n,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] s,
  input  logic [DW-1:0] d,
  output logic          zf,
  output logic          cf,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CNT_W = $clog2(IMM_TIMEOUT + 1);

  state_e         state;
  op_e            op_q;
  logic           in_ready_q;
  logic [CNT_W-1:0] cnt;

  op_e            dec_op;
  logic [1:0]     dec_src;
  logic [1:0]     dec_dst;
  logic           dec_legal;

  logic [DW-1:0]  alu_res;
  logic           alu_carry;
  logic           alu_zero;

  assign dec_op    = op_e'(host.in_data[7:4]);
  assign dec_src   = host.in_data[3:2];
  assign dec_dst   = host.in_data[1:0];
  assign dec_legal = instr_legal(host.in_data[7:0]);

  assign host.in_ready = in_ready_q;

  reg_group_ctrl_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (d),
    .b      (s),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_NOP;
      in_ready_q <= 1'b1;
      raa        <= REG_A;
      rwba       <= REG_A;
      we_n       <= 1'b1;
      wdata      <= '0;
      zf         <= 1'b0;
      cf         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host.in_valid) begin
            if (!dec_legal) begin
              err <= 1'b1;
            end else begin
              err  <= 1'b0;
              op_q <= dec_op;
              if (dec_op == OP_NOP) begin
                done <= 1'b1;
              end else if (dec_op == OP_LDI) begin
                state <= ST_IMM;
                rwba  <= dec_dst;
                busy  <= 1'b1;
                cnt   <= '0;
              end else begin
                state      <= ST_EXEC;
                raa        <= dec_src;
                rwba       <= dec_dst;
                busy       <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        // Waiting for the immediate byte; give up after IMM_TIMEOUT idle cycles.
        ST_IMM: begin
          if (host.in_valid) begin
            wdata      <= host.in_data;
            we_n       <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= ST_WRITE;
          end else if (cnt == CNT_W'(IMM_TIMEOUT - 1)) begin
            state <= ST_IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // s/d are valid for raa/rwba set on entry; latch result and flags.
        ST_EXEC: begin
          wdata <= alu_res;
          zf    <= alu_zero;
          cf    <= alu_carry;
          we_n  <= 1'b0;
          state <= ST_WRITE;
        end
        // Register group commits on this cycle's negedge.
        ST_WRITE: begin
          we_n       <= 1'b1;
          done       <= 1'b1;
          busy       <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          we_n       <= 1'b1;
          busy       <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
